// File: rtl/sys_arr_pkg.sv
// Shared types and defaults for the systolic-array job controller.
// SYS_ARR_TIMEOUT_EN enables the RUN-state watchdog in sys_arr_sched.
package sys_arr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RST_HOLD = 2'd1,
    ST_RST_REL  = 2'd2,
    ST_RUN      = 2'd3
  } state_e;

  localparam int DEF_N       = 4;
  localparam int DEF_DW      = 32;
  localparam int DEF_RST_CYC = 2;
  localparam int DEF_TIMEOUT = 1024;

  // Hold counter only has to reach RST_CYC-1.
  function automatic int rst_cnt_w(input int cyc);
    return (cyc <= 2) ? 1 : $clog2(cyc);
  endfunction

endpackage

// File: rtl/sys_arr_op_bank.sv
// N x DW operand register file with per-lane valid mask and all-valid flag.
module sys_arr_op_bank #(
  parameter int N  = 4,
  parameter int DW = 32,
  parameter int AW = $clog2(N)
) (
  input  logic          clk,
  input  logic          g_rst_n,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  input  logic          freeze,
  input  logic          clr,
  output logic [N*DW-1:0] data_flat,
  output logic          all_vld
);

  localparam logic [AW:0] LANES = (AW+1)'(N);

  logic [N-1:0][DW-1:0] mem_q, mem_d;
  logic [N-1:0]         mask_q, mask_d;
  logic                 wr_en;

  // Out-of-range lanes are dropped; freeze keeps operands stable during a job.
  assign wr_en = we && !freeze && ({1'b0, addr} < LANES);

  always_comb begin
    mem_d  = mem_q;
    mask_d = clr ? '0 : mask_q;
    if (wr_en) begin
      mem_d[addr]  = wdata;
      mask_d[addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge g_rst_n) begin
    if (!g_rst_n) begin
      mem_q  <= '0;
      mask_q <= '0;
    end else begin
      mem_q  <= mem_d;
      mask_q <= mask_d;
    end
  end

  assign data_flat = mem_q;
  assign all_vld   = &mask_q;

endmodule

// File: rtl/sys_arr_sched.sv
// Job controller for an N-lane systolic-array worker: operand banks, reset/enable
// sequencing and completion tracking. SYS_ARR_TIMEOUT_EN adds a RUN watchdog.
module sys_arr_sched
  import sys_arr_pkg::*;
#(
  parameter int N       = DEF_N,
  parameter int DW      = DEF_DW,
  parameter int AW      = $clog2(N),
  parameter int RST_CYC = DEF_RST_CYC,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic            clk,
  input  logic            g_rst_n,
  input  logic            start,
  input  logic [AW-1:0]   x_addr,
  input  logic            x_valid,
  input  logic [DW-1:0]   x_data,
  input  logic [AW-1:0]   y_addr,
  input  logic            y_valid,
  input  logic [DW-1:0]   y_data,
  output logic            ops_ready,
  output logic            busy,
  output logic            done,
  output logic            start_rej,
  output logic            err,
  output logic [CNT_W-1:0] job_cnt,
  output logic            wk_rst,
  output logic [N*DW-1:0] wk_a,
  output logic [N*DW-1:0] wk_b,
  input  logic            wk_done
);

  localparam int RCW = rst_cnt_w(RST_CYC);

  state_e           state_q, state_d;
  logic [RCW-1:0]   rcnt_q, rcnt_d;
  logic             busy_q, busy_d, done_q, done_d, rej_q, rej_d, wk_rst_q, wk_rst_d;
  logic [CNT_W-1:0] job_cnt_q, job_cnt_d;
  logic             x_all, y_all, frz, mask_clr;

`ifdef SYS_ARR_TIMEOUT_EN
  localparam int TCW = $clog2(TIMEOUT + 1);
  logic [TCW-1:0] tcnt_q, tcnt_d;
  logic           err_q, err_d;
`endif

  assign frz       = (state_q != ST_IDLE);
  assign mask_clr  = (state_q == ST_RUN) && wk_done;
  assign ops_ready = x_all & y_all;

  sys_arr_op_bank #(.N(N), .DW(DW), .AW(AW)) u_xbank (
    .clk(clk), .g_rst_n(g_rst_n), .we(x_valid), .addr(x_addr), .wdata(x_data),
    .freeze(frz), .clr(mask_clr), .data_flat(wk_a), .all_vld(x_all)
  );

  sys_arr_op_bank #(.N(N), .DW(DW), .AW(AW)) u_ybank (
    .clk(clk), .g_rst_n(g_rst_n), .we(y_valid), .addr(y_addr), .wdata(y_data),
    .freeze(frz), .clr(mask_clr), .data_flat(wk_b), .all_vld(y_all)
  );

  always_comb begin
    state_d   = state_q;
    rcnt_d    = rcnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    rej_d     = 1'b0;
    wk_rst_d  = wk_rst_q;
    job_cnt_d = job_cnt_q;
`ifdef SYS_ARR_TIMEOUT_EN
    tcnt_d    = tcnt_q;
    err_d     = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        // Also terminates the one-cycle worker reset pulse after a timeout.
        wk_rst_d = 1'b0;
        if (start && ops_ready) begin
          state_d  = ST_RST_HOLD;
          wk_rst_d = 1'b1;
          rcnt_d   = '0;
`ifdef SYS_ARR_TIMEOUT_EN
          err_d    = 1'b0;
`endif
        end else if (start) begin
          rej_d = 1'b1;
        end
      end
      ST_RST_HOLD: begin
        if (rcnt_q == RCW'(RST_CYC - 1)) begin
          state_d  = ST_RST_REL;
          wk_rst_d = 1'b0;
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end
      ST_RST_REL: begin
        state_d = ST_RUN;
        busy_d  = 1'b1;
`ifdef SYS_ARR_TIMEOUT_EN
        tcnt_d  = '0;
`endif
      end
      ST_RUN: begin
        if (wk_done) begin
          state_d   = ST_IDLE;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          job_cnt_d = job_cnt_q + 1'b1;
        end
`ifdef SYS_ARR_TIMEOUT_EN
        else if (tcnt_q == TCW'(TIMEOUT - 1)) begin
          state_d  = ST_IDLE;
          busy_d   = 1'b0;
          err_d    = 1'b1;
          wk_rst_d = 1'b1;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge g_rst_n) begin
    if (!g_rst_n) begin
      state_q   <= ST_IDLE;
      rcnt_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rej_q     <= 1'b0;
      wk_rst_q  <= 1'b0;
      job_cnt_q <= '0;
`ifdef SYS_ARR_TIMEOUT_EN
      tcnt_q    <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      rcnt_q    <= rcnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rej_q     <= rej_d;
      wk_rst_q  <= wk_rst_d;
      job_cnt_q <= job_cnt_d;
`ifdef SYS_ARR_TIMEOUT_EN
      tcnt_q    <= tcnt_d;
      err_q     <= err_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign start_rej = rej_q;
  assign wk_rst    = wk_rst_q;
  assign job_cnt   = job_cnt_q;
`ifdef SYS_ARR_TIMEOUT_EN
  assign err       = err_q;
`else
  assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_sys_arr_sched.sv
// Scoreboard bench for sys_arr_sched with N=5 (non-power-of-2) and a 2-bit job counter.
module tb_sys_arr_sched;

  localparam int N = 5, DW = 32, AW = $clog2(N), CNT_W = 2, RST_CYC = 2, TIMEOUT = 16;

  logic clk, g_rst_n, start, x_valid, y_valid, wk_done;
  logic [AW-1:0] x_addr, y_addr;
  logic [DW-1:0] x_data, y_data;
  logic ops_ready, busy, done, start_rej, err, wk_rst;
  logic [CNT_W-1:0] job_cnt;
  logic [N*DW-1:0] wk_a, wk_b;

  sys_arr_sched #(.N(N), .DW(DW), .RST_CYC(RST_CYC), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .g_rst_n(g_rst_n), .start(start),
    .x_addr(x_addr), .x_valid(x_valid), .x_data(x_data),
    .y_addr(y_addr), .y_valid(y_valid), .y_data(y_data),
    .ops_ready(ops_ready), .busy(busy), .done(done), .start_rej(start_rej), .err(err),
    .job_cnt(job_cnt), .wk_rst(wk_rst), .wk_a(wk_a), .wk_b(wk_b), .wk_done(wk_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N*DW-1:0]  a;
    logic [N*DW-1:0]  b;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int checks = 0, fails = 0;

  logic [DW-1:0]    xm [N];
  logic [DW-1:0]    ym [N];
  logic [N-1:0]     xv, yv;
  logic [CNT_W-1:0] cnt_m;
  logic             idle_m;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [N*DW-1:0] pk(input logic [DW-1:0] m [N]);
    logic [N*DW-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r[i*DW +: DW] = m[i];
    return r;
  endfunction

  // Completion monitor: every done pulse must match the oldest accepted job.
  always @(negedge clk) begin
    if (g_rst_n && done) begin
      if (sb.size() == 0) chk("done_unexp", 256'(done), 256'(0));
      else begin
        mon_e = sb.pop_front();
        chk("sb_a", 256'(wk_a), 256'(mon_e.a));
        chk("sb_b", 256'(wk_b), 256'(mon_e.b));
        chk("sb_cnt", 256'(job_cnt), 256'(mon_e.cnt));
      end
    end
  end

  // Lane < 0 means no write on that bank; lanes >= N exercise address rejection.
  task automatic wr(input int lx, input logic [DW-1:0] dx, input int ly, input logic [DW-1:0] dy);
    x_valid = (lx >= 0); x_addr = AW'(lx); x_data = dx;
    y_valid = (ly >= 0); y_addr = AW'(ly); y_data = dy;
    @(negedge clk);
    x_valid = 1'b0; y_valid = 1'b0;
    if (idle_m && lx >= 0 && lx < N) begin xm[lx] = dx; xv[lx] = 1'b1; end
    if (idle_m && ly >= 0 && ly < N) begin ym[ly] = dy; yv[ly] = 1'b1; end
  endtask

  task automatic load(input logic [DW-1:0] xb, input logic [DW-1:0] yb);
    for (int i = 0; i < N; i++) wr(i, xb * DW'(i + 1), i, yb + DW'(i));
    chk("ops_ready_load", 256'(ops_ready), 256'(&xv & &yv));
  endtask

  task automatic start_job();
    sb.push_back('{a: pk(xm), b: pk(ym), cnt: cnt_m + 1'b1});
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    idle_m = 1'b0;
    chk("wk_rst_t0", 256'(wk_rst), 256'(1));
    chk("busy_t0", 256'(busy), 256'(0));
    chk("rej_t0", 256'(start_rej), 256'(0));
    chk("err_clr", 256'(err), 256'(0));
    @(negedge clk);
    chk("wk_rst_t1", 256'(wk_rst), 256'(1));
    @(negedge clk);
    chk("wk_rst_t2", 256'(wk_rst), 256'(0));
    chk("busy_t2", 256'(busy), 256'(0));
    @(negedge clk);
    chk("busy_t3", 256'(busy), 256'(1));
  endtask

  task automatic finish_job();
    wk_done = 1'b1;
    @(negedge clk);
    wk_done = 1'b0;
    cnt_m = cnt_m + 1'b1;
    xv = '0; yv = '0; idle_m = 1'b1;
    chk("done_pulse", 256'(done), 256'(1));
    chk("busy_fall", 256'(busy), 256'(0));
    chk("job_cnt", 256'(job_cnt), 256'(cnt_m));
    chk("ops_clr", 256'(ops_ready), 256'(0));
    @(negedge clk);
    chk("done_1cyc", 256'(done), 256'(0));
  endtask

  initial begin
    g_rst_n = 1'b1; start = 1'b0; wk_done = 1'b0;
    x_valid = 1'b0; y_valid = 1'b0; x_addr = '0; y_addr = '0; x_data = '0; y_data = '0;
    for (int i = 0; i < N; i++) begin xm[i] = '0; ym[i] = '0; end
    xv = '0; yv = '0; cnt_m = '0; idle_m = 1'b1;
    #2 g_rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 256'(busy), 256'(0));
    chk("rst_wk_rst", 256'(wk_rst), 256'(0));
    chk("rst_job_cnt", 256'(job_cnt), 256'(0));
    chk("rst_flags", 256'({ops_ready, done, start_rej, err}), 256'(0));
    chk("rst_wk_a", 256'(wk_a), 256'(0));
    g_rst_n = 1'b1;
    @(negedge clk);

    // Incomplete Y bank: start rejected for exactly one cycle.
    for (int i = 0; i < N; i++) wr(i, 32'h11 * DW'(i + 1), (i < N - 1) ? i : -1, 32'hA1 + DW'(i));
    chk("ops_partial", 256'(ops_ready), 256'(0));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("rej_pulse", 256'(start_rej), 256'(1));
    chk("rej_no_rst", 256'(wk_rst), 256'(0));
    @(negedge clk);
    chk("rej_1cyc", 256'(start_rej), 256'(0));
    chk("rej_idle", 256'({busy, wk_rst}), 256'(0));

    // Complete Y, then out-of-range lanes must not disturb the banks.
    wr(-1, '0, N - 1, 32'hA1 + DW'(N - 1));
    wr(N, 32'hBAD0, 7, 32'hBAD1);
    chk("oob_a", 256'(wk_a), 256'(pk(xm)));
    chk("oob_b", 256'(wk_b), 256'(pk(ym)));
    chk("ops_full", 256'(ops_ready), 256'(1));

    // Job 1: frozen operands, start while busy ignored.
    start_job();
    chk("wk_a_pack", 256'(wk_a), 256'(160'h00000055_00000044_00000033_00000022_00000011));
    wr(0, 32'hDEAD, -1, '0);
    chk("frozen_a", 256'(wk_a), 256'(pk(xm)));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_start_norej", 256'(start_rej), 256'(0));
    chk("busy_hold", 256'({busy, wk_rst}), 256'(2'b10));
    finish_job();

    // Masks cleared: start rejected; wk_done outside RUN ignored.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("rej_after_done", 256'(start_rej), 256'(1));
    wk_done = 1'b1;
    @(negedge clk);
    wk_done = 1'b0;
    chk("idle_wk_done", 256'({done, job_cnt}), 256'({1'b0, cnt_m}));

    // Jobs 2..4 wrap the 2-bit counter to 0.
    for (int j = 0; j < 3; j++) begin
      load(DW'($urandom_range(1, 255)), DW'($urandom));
      start_job();
      repeat (j + 1) @(negedge clk);
      finish_job();
    end

    // Asynchronous reset in RUN: immediate clear, no completion afterwards.
    load(32'h3, 32'h7);
    start_job();
    #2 g_rst_n = 1'b0;
    #1;
    chk("arst_busy", 256'(busy), 256'(0));
    chk("arst_wk_rst", 256'(wk_rst), 256'(0));
    chk("arst_cnt", 256'(job_cnt), 256'(0));
    sb.delete();
    for (int i = 0; i < N; i++) begin xm[i] = '0; ym[i] = '0; end
    xv = '0; yv = '0; cnt_m = '0; idle_m = 1'b1;
    @(negedge clk);
    g_rst_n = 1'b1;
    wk_done = 1'b1;
    @(negedge clk);
    wk_done = 1'b0;
    chk("arst_no_done", 256'(done), 256'(0));
    chk("arst_banks", 256'(wk_a | wk_b), 256'(0));

`ifdef SYS_ARR_TIMEOUT_EN
    load(32'h5, 32'h9);
    start_job();
    repeat (TIMEOUT - 1) @(negedge clk);
    chk("to_pre_busy", 256'(busy), 256'(1));
    @(negedge clk);
    chk("to_err", 256'(err), 256'(1));
    chk("to_busy", 256'(busy), 256'(0));
    chk("to_wk_rst", 256'(wk_rst), 256'(1));
    chk("to_no_done", 256'({done, job_cnt}), 256'({1'b0, cnt_m}));
    sb.delete();
    idle_m = 1'b1;
    @(negedge clk);
    chk("to_wk_rst_1cyc", 256'(wk_rst), 256'(0));
    chk("to_masks_kept", 256'(ops_ready), 256'(1));
    start_job();
    finish_job();
`else
    load(32'h5, 32'h9);
    start_job();
    repeat (3 * TIMEOUT) @(negedge clk);
    chk("no_to_busy", 256'(busy), 256'(1));
    chk("no_to_err", 256'(err), 256'(0));
    finish_job();
`endif

    chk("sb_drained", 256'(sb.size()), 256'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/sys_arr_sched.md
Name: sys_arr_sched

Overview:
Parametrised job controller for an N-lane systolic-array worker. It holds two operand banks (X, Y) of N words each and tracks which words have been written. On start it sequences the worker's reset and enable, then waits for completion, reporting busy, done and job count. It sits between the host-side load/start interface and an external systolic-array core, whose result readout is outside this block.

Parameters:
N, 4, operand lanes per bank (≥2)
DW, 32, operand word width
AW, $clog2(N), lane address width (derived, do not override)
RST_CYC, 2, cycles wk_rst is held high (≥1)
CNT_W, 8, job counter width
TIMEOUT, 1024, RUN-state cycle limit (used only with SYS_ARR_TIMEOUT_EN)

Ports:
clk  in  1  clock
g_rst_n  in  1  global reset, asynchronous, active-low
start  in  1  job request, level-sampled
x_addr  in  AW  X lane index
x_valid  in  1  X write strobe
x_data  in  DW  X write data
y_addr  in  AW  Y lane index
y_valid  in  1  Y write strobe
y_data  in  DW  Y write data
ops_ready  out  1  all N X words and all N Y words written since last completion
busy  out  1  job in flight (worker enabled)
done  out  1  one-cycle completion pulse
start_rej  out  1  one-cycle pulse: start seen while not acceptable
err  out  1  sticky timeout flag
job_cnt  out  CNT_W  completed jobs, wraps
wk_rst  out  1  worker reset, active-high
wk_a  out  N*DW  X bank flattened, lane 0 in bits [DW-1:0]
wk_b  out  N*DW  Y bank flattened, lane 0 in bits [DW-1:0]
wk_done  in  1  worker completion strobe

Behaviour:
- Reset values: all outputs 0. Banks are 0. Valid masks are 0. State is IDLE. Async assert; deassert is synchronous to clk, handled outside this block.
- Banks:
  - A write with *_valid=1 in IDLE, and addr<N, stores the data and sets that lane's mask bit.
  - addr≥N is ignored.
  - X and Y writes are independent and may occur in the same cycle.
  - Rewriting a lane overwrites the data; its mask bit stays set.
  - Writes in any non-IDLE state are ignored, so operands are frozen during a job.
- ops_ready = &x_mask & &y_mask, taken from registered masks. A write in the same cycle as start does not count toward acceptance.
- FSM: IDLE → RST_HOLD → RST_REL → RUN → IDLE.
  - IDLE: start=1 and ops_ready=1 → RST_HOLD, wk_rst←1, counter cleared.
  - IDLE: start=1 and ops_ready=0 → start_rej pulse for 1 cycle; stay in IDLE.
  - RST_HOLD: wk_rst stays 1 for exactly RST_CYC cycles, then → RST_REL with wk_rst←0.
  - RST_REL: one settle cycle, then → RUN with busy←1.
  - RUN: wk_done=1 → IDLE. In the same edge: busy←0, done←1 for 1 cycle, job_cnt+1 (mod 2^CNT_W), both masks cleared (bank data retained).
- Latency: start accepted at edge t. wk_rst is high from t to t+RST_CYC. busy rises at t+RST_CYC+1. The default RST_CYC=2 gives busy at t+3.
- start while not in IDLE: ignored, no start_rej.
- wk_done outside RUN: ignored.
- err is cleared on the next accepted start.
- Reset mid-job: g_rst_n low returns everything to reset values immediately. No done pulse is produced.

Optional Feature:
SYS_ARR_TIMEOUT_EN:
- Defined:
  - A counter runs in RUN.
  - If TIMEOUT cycles pass with no wk_done: → IDLE, busy←0, err←1, wk_rst pulsed high for 1 cycle.
  - No done pulse, job_cnt unchanged, masks retained so the job can be restarted.
  - wk_done arriving on the same cycle as the timeout wins and counts as normal completion.
- Undefined: RUN waits indefinitely, err is tied 0, and no counter logic is present.

Decomposition:
- Package sys_arr_pkg holds:
  - state enum (IDLE, RST_HOLD, RST_REL, RUN);
  - default constants for N, DW, RST_CYC, TIMEOUT;
  - a function computing the RST_HOLD counter width.
- One sub-module, sys_arr_op_bank: N×DW register file with write strobe, valid mask, mask clear, freeze input, flattened output and all-valid flag. It is instantiated twice (X, Y).

Test Plan:
- Write X/Y lanes 0..3 with 0x11..0x44 / 0xA1..0xA4, start=1 at edge t → wk_rst high for t..t+2, busy at t+3; wk_a == 0x00000044_00000033_00000022_00000011.
- Write only 3 Y lanes, start=1 → start_rej pulses 1 cycle, wk_rst stays 0, state stays IDLE.
- During busy, write x_addr=0 with 0xDEAD → wk_a unchanged. Then wk_done=1 → done 1 cycle, busy 0, job_cnt 0→1, ops_ready 0.
- CNT_W=2: run 4 complete jobs → job_cnt reads 1,2,3,0. x_addr=N (with non-power-of-2 N=5) → write ignored.
- g_rst_n low in RUN → busy, wk_rst and job_cnt are 0 asynchronously; a later wk_done gives no done pulse.
- With SYS_ARR_TIMEOUT_EN and TIMEOUT=16, withhold wk_done → after 16 RUN cycles: err=1, busy=0, 1-cycle wk_rst, no done. Restart → err clears.
